// File: rtl/maple_fifo_arbiter.sv
// Round-robin arbiter sharing the FX2 EP6 IN stream writer between Maple
// channel receivers: tags each packet, paces bytes to the writer's cycle
// budget and leaves a quiet gap between packets.
module maple_fifo_arbiter #(
   parameter int         N_CH         = 4,
   parameter int         START_CYCLES = 3,
   parameter int         BYTE_CYCLES  = 3,
   parameter int         GAP_CYCLES   = 3,
   parameter int         MAX_BYTES    = 255,
   parameter logic [7:0] TAG_BASE     = 8'hA0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   req_enable,
   input  logic [N_CH-1:0]   req_ready,
   input  logic [8*N_CH-1:0] req_data,
   output logic [N_CH-1:0]   req_ack,
   output logic [N_CH-1:0]   grant,
   output logic              out_enable,
   output logic              out_ready,
   output logic [7:0]        out_data,
   output logic              truncated
);

   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {IDLE, ARB, START, PACE, XFER, GAP} state_t;

   state_t            state, state_n;
   logic [7:0]        wait_cnt, wait_n;
   logic [7:0]        byte_cnt, byte_n;
   logic [CW-1:0]     last, last_n;
   logic              dropped, dropped_n;
   logic [N_CH-1:0]   grant_n, ack_n;
   logic              oe_n, rdy_n, trunc_n;
   logic [7:0]        data_n;

   logic              found;
   logic [CW-1:0]     pick, cand;
   int                idx;
   logic              owner_en, owner_rdy;
   logic [7:0]        owner_data;

   // The owner is always the last granted index, so its request lines are
   // selected through the round-robin pointer.
   assign owner_en   = req_enable[last];
   assign owner_rdy  = req_ready[last];
   assign owner_data = req_data[{last, 3'b000} +: 8];

   // State register and registered outputs; reset wins over any packet in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         byte_cnt   <= '0;
         last       <= CW'(N_CH - 1);
         dropped    <= 1'b0;
         grant      <= '0;
         req_ack    <= '0;
         out_enable <= 1'b0;
         out_ready  <= 1'b0;
         out_data   <= '0;
         truncated  <= 1'b0;
      end else begin
         state      <= state_n;
         wait_cnt   <= wait_n;
         byte_cnt   <= byte_n;
         last       <= last_n;
         dropped    <= dropped_n;
         grant      <= grant_n;
         req_ack    <= ack_n;
         out_enable <= oe_n;
         out_ready  <= rdy_n;
         out_data   <= data_n;
         truncated  <= trunc_n;
      end
   end

   // Round-robin search starting just after the previous owner, wrapping once.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      idx   = 0;
      for (int i = 1; i <= N_CH; i++) begin
         idx  = (int'(last) + i) % N_CH;
         cand = CW'(idx);
         if (!found && req_enable[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and next-output logic; pulses default low, levels hold.
   always_comb begin
      state_n   = state;
      wait_n    = wait_cnt;
      byte_n    = byte_cnt;
      last_n    = last;
      dropped_n = dropped;
      grant_n   = grant;
      ack_n     = '0;
      oe_n      = out_enable;
      rdy_n     = 1'b0;
      data_n    = out_data;
      trunc_n   = 1'b0;

      case (state)
         IDLE: begin
            if (|req_enable) state_n = ARB;
         end
         ARB: begin
            if (found) begin
               grant_n       = '0;
               grant_n[pick] = 1'b1;
               last_n        = pick;
               byte_n        = '0;
               wait_n        = '0;
               dropped_n     = 1'b0;
               oe_n          = 1'b1;
               state_n       = START;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            if (!owner_en) dropped_n = 1'b1;
            if (int'(wait_cnt) >= START_CYCLES - 2) begin
               rdy_n   = 1'b1;
               data_n  = TAG_BASE | 8'(last);
               wait_n  = '0;
               state_n = PACE;
            end else begin
               wait_n = wait_cnt + 8'd1;
            end
         end
         PACE: begin
            if (!owner_en) dropped_n = 1'b1;
            if (int'(wait_cnt) >= BYTE_CYCLES - 2) begin
               wait_n  = '0;
               state_n = XFER;
            end else begin
               wait_n = wait_cnt + 8'd1;
            end
         end
         XFER: begin
            if (dropped || !owner_en) begin
               oe_n    = 1'b0;
               grant_n = '0;
               wait_n  = '0;
               state_n = GAP;
            end else if (owner_rdy) begin
               rdy_n       = 1'b1;
               data_n      = owner_data;
               ack_n[last] = 1'b1;
               byte_n      = byte_cnt + 8'd1;
               wait_n      = '0;
               if (byte_cnt + 8'd1 == 8'(MAX_BYTES)) begin
                  trunc_n = 1'b1;
                  state_n = GAP;
               end else begin
                  state_n = PACE;
               end
            end
         end
         GAP: begin
            // After a truncated grant the final byte pulse is still on the
            // writer with enable high, so the quiet period is only counted
            // once out_enable has actually fallen.
            oe_n    = 1'b0;
            grant_n = '0;
            if (!out_enable) begin
               if (int'(wait_cnt) >= GAP_CYCLES - 1) begin
                  wait_n  = '0;
                  state_n = IDLE;
               end else begin
                  wait_n = wait_cnt + 8'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_maple_fifo_arbiter.sv
// Scoreboard bench for maple_fifo_arbiter: directed requester traffic is
// issued by the stimulus, expected writer pulses are queued, and a monitor
// pops and compares on every out_ready pulse.
module tb_maple_fifo_arbiter;

   localparam int N_CH         = 4;
   localparam int START_CYCLES = 3;
   localparam int BYTE_CYCLES  = 3;
   localparam int GAP_CYCLES   = 3;
   localparam int MAX_BYTES    = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_enable;
   logic [3:0]   req_ready;
   logic [31:0]  req_data;
   logic [3:0]   req_ack;
   logic [3:0]   grant;
   logic         out_enable;
   logic         out_ready;
   logic [7:0]   out_data;
   logic         truncated;

   typedef struct packed {
      logic [3:0] grant;
      logic [7:0] data;
      logic [3:0] ack;
      logic       trunc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   pulse_count = 0;

   // Requester model state, owned by the driver process.
   logic [7:0] rbuf [4][16];
   logic [3:0] head [4];
   logic [3:0] tail [4];
   logic       cmd_valid;
   logic       cmd_clear;
   int         cmd_ch;
   logic [7:0] cmd_byte;
   logic       gate;
   logic [3:0] stall;

   maple_fifo_arbiter #(
      .N_CH(N_CH), .START_CYCLES(START_CYCLES), .BYTE_CYCLES(BYTE_CYCLES),
      .GAP_CYCLES(GAP_CYCLES), .MAX_BYTES(MAX_BYTES), .TAG_BASE(8'hA0)
   ) dut (
      .clk(clk), .reset(reset),
      .req_enable(req_enable), .req_ready(req_ready), .req_data(req_data),
      .req_ack(req_ack), .grant(grant),
      .out_enable(out_enable), .out_ready(out_ready), .out_data(out_data),
      .truncated(truncated)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual === required) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
   endtask

   task automatic pushExpected(input logic [3:0] g, input logic [7:0] d, input logic [3:0] a, input logic t);
      exp_t e;
      e.grant = g; e.data = d; e.ack = a; e.trunc = t;
      sb.push_back(e);
   endtask

   task automatic loadByte(input int ch, input logic [7:0] b);
      @(posedge clk); #2;
      cmd_valid = 1'b1; cmd_ch = ch; cmd_byte = b;
      @(posedge clk); #2;
      cmd_valid = 1'b0;
   endtask

   task automatic setGate(input logic v);
      @(posedge clk); #2;
      gate = v;
   endtask

   task automatic setStall(input logic [3:0] v);
      @(posedge clk); #2;
      stall = v;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_grant"}, 32'(grant), 32'h0);
      checkOutput({tag, "_req_ack"}, 32'(req_ack), 32'h0);
      checkOutput({tag, "_out_enable"}, 32'(out_enable), 32'h0);
      checkOutput({tag, "_out_ready"}, 32'(out_ready), 32'h0);
      checkOutput({tag, "_out_data"}, 32'(out_data), 32'h0);
      checkOutput({tag, "_truncated"}, 32'(truncated), 32'h0);
   endtask

   // Polls just after the rising edge so the caller stays in that phase.
   task automatic waitSbSize(input string name, input int size, input int budget);
      int n = 0;
      while (sb.size() > size && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      checkOutput({name, "_progress"}, 32'(sb.size() > size), 32'h0);
   endtask

   task automatic drainPackets(input string name);
      waitSbSize(name, 0, 3000);
      if (sb.size() != 0) sb.delete();
      repeat (12) @(negedge clk);
   endtask

   // Requester model: pops a byte on its ack, keeps enable high while bytes remain.
   initial begin
      for (int c = 0; c < 4; c++) begin head[c] = '0; tail[c] = '0; end
      req_enable = '0; req_ready = '0; req_data = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            if (cmd_clear) begin
               head[c] = '0; tail[c] = '0;
            end else if (req_ack[c] && head[c] != tail[c]) begin
               head[c] = head[c] + 4'd1;
            end
         end
         if (cmd_valid) begin
            rbuf[cmd_ch][tail[cmd_ch]] = cmd_byte;
            tail[cmd_ch] = tail[cmd_ch] + 4'd1;
         end
         for (int c = 0; c < 4; c++) begin
            req_enable[c]      = gate && (head[c] != tail[c]);
            req_ready[c]       = gate && (head[c] != tail[c]) && !stall[c];
            req_data[8*c +: 8] = (head[c] != tail[c]) ? rbuf[c][head[c]] : 8'h00;
         end
      end
   end

   // Monitor: timing rules on the writer side plus scoreboard compare per pulse.
   initial begin
      int   cyc = 0;
      int   last_pulse = 0;
      int   en_age = 0;
      int   low_run = 0;
      logic had_packet = 1'b0;
      logic first_in_pkt = 1'b0;
      logic prev_oe = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            had_packet = 1'b0;
            prev_oe    = 1'b0;
            low_run    = 0;
         end else begin
            if (out_enable && !prev_oe) begin
               // GAP plus the IDLE and ARB cycles all keep enable low.
               if (had_packet) checkOutput("gap_low_cycles", 32'(low_run >= GAP_CYCLES + 2), 32'h1);
               en_age       = 0;
               first_in_pkt = 1'b1;
            end else if (out_enable) begin
               en_age++;
            end
            if (!out_enable) begin
               if (prev_oe) begin low_run = 0; had_packet = 1'b1; end
               low_run++;
            end
            prev_oe = out_enable;

            if (out_ready) begin
               pulse_count++;
               checkOutput("ready_with_enable", 32'(out_enable), 32'h1);
               if (first_in_pkt) begin
                  // Enable shows the cycle after ARB, the tag three cycles after ARB.
                  checkOutput("tag_latency", 32'(en_age), 32'(START_CYCLES - 1));
                  first_in_pkt = 1'b0;
               end else begin
                  checkOutput("byte_spacing", 32'(cyc - last_pulse >= BYTE_CYCLES), 32'h1);
               end
               last_pulse = cyc;
               checkOutput("pulse_expected", 32'(sb.size() != 0), 32'h1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  checkOutput("out_data", 32'(out_data), 32'(e.data));
                  checkOutput("grant", 32'(grant), 32'(e.grant));
                  checkOutput("req_ack", 32'(req_ack), 32'(e.ack));
                  checkOutput("truncated", 32'(truncated), 32'(e.trunc));
               end
            end else if (req_ack != 4'h0 || truncated) begin
               checkOutput("strobe_without_pulse", {27'h0, req_ack, truncated}, 32'h0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, each queueing its hand-computed writer pulses first.
   initial begin
      int base;
      reset = 1'b1; gate = 1'b0; stall = '0;
      cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_ch = 0; cmd_byte = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("por");
      @(posedge clk); #2;
      reset = 1'b0;

      // Single requester on channel 1, two bytes.
      $display("[TB] single requester");
      loadByte(1, 8'h11);
      loadByte(1, 8'h22);
      pushExpected(4'b0010, 8'hA1, 4'b0000, 1'b0);
      pushExpected(4'b0010, 8'h11, 4'b0010, 1'b0);
      pushExpected(4'b0010, 8'h22, 4'b0010, 1'b0);
      setGate(1'b1);
      drainPackets("single");

      // Round robin from a fresh pointer: 0, 2, 3, then 0 again.
      $display("[TB] round robin");
      setGate(1'b0);
      @(posedge clk); #2; reset = 1'b1;
      repeat (2) @(posedge clk); #2; reset = 1'b0;
      loadByte(0, 8'h01);
      loadByte(2, 8'h02);
      loadByte(3, 8'h03);
      pushExpected(4'b0001, 8'hA0, 4'b0000, 1'b0);
      pushExpected(4'b0001, 8'h01, 4'b0001, 1'b0);
      pushExpected(4'b0100, 8'hA2, 4'b0000, 1'b0);
      pushExpected(4'b0100, 8'h02, 4'b0100, 1'b0);
      pushExpected(4'b1000, 8'hA3, 4'b0000, 1'b0);
      pushExpected(4'b1000, 8'h03, 4'b1000, 1'b0);
      setGate(1'b1);
      waitSbSize("rr_first", 4, 500);
      begin
         int n = 0;
         while (grant[0] !== 1'b0 && n < 200) begin @(posedge clk); #2; n++; end
      end
      checkOutput("rr_ch0_released", 32'(grant[0]), 32'h0);
      pushExpected(4'b0001, 8'hA0, 4'b0000, 1'b0);
      pushExpected(4'b0001, 8'h04, 4'b0001, 1'b0);
      loadByte(0, 8'h04);
      drainPackets("rr");

      // Wrap: move the pointer to 3, then 0 must beat 3.
      $display("[TB] wrap");
      setGate(1'b0);
      loadByte(3, 8'h31);
      pushExpected(4'b1000, 8'hA3, 4'b0000, 1'b0);
      pushExpected(4'b1000, 8'h31, 4'b1000, 1'b0);
      setGate(1'b1);
      drainPackets("wrap_setup");
      setGate(1'b0);
      loadByte(0, 8'h41);
      loadByte(3, 8'h42);
      pushExpected(4'b0001, 8'hA0, 4'b0000, 1'b0);
      pushExpected(4'b0001, 8'h41, 4'b0001, 1'b0);
      pushExpected(4'b1000, 8'hA3, 4'b0000, 1'b0);
      pushExpected(4'b1000, 8'h42, 4'b1000, 1'b0);
      setGate(1'b1);
      drainPackets("wrap");

      // Truncation at four bytes; channel 1 is served before channel 0 resumes.
      $display("[TB] truncation");
      setGate(1'b0);
      for (int i = 0; i < 6; i++) loadByte(0, 8'h50 + 8'(i));
      loadByte(1, 8'h60);
      pushExpected(4'b0001, 8'hA0, 4'b0000, 1'b0);
      pushExpected(4'b0001, 8'h50, 4'b0001, 1'b0);
      pushExpected(4'b0001, 8'h51, 4'b0001, 1'b0);
      pushExpected(4'b0001, 8'h52, 4'b0001, 1'b0);
      pushExpected(4'b0001, 8'h53, 4'b0001, 1'b1);
      pushExpected(4'b0010, 8'hA1, 4'b0000, 1'b0);
      pushExpected(4'b0010, 8'h60, 4'b0010, 1'b0);
      pushExpected(4'b0001, 8'hA0, 4'b0000, 1'b0);
      pushExpected(4'b0001, 8'h54, 4'b0001, 1'b0);
      pushExpected(4'b0001, 8'h55, 4'b0001, 1'b0);
      setGate(1'b1);
      drainPackets("trunc");

      // Stall: channel 2 holds enable with ready low for 50 cycles.
      $display("[TB] stall");
      setGate(1'b0);
      setStall(4'b0100);
      loadByte(2, 8'h5A);
      pushExpected(4'b0100, 8'hA2, 4'b0000, 1'b0);
      setGate(1'b1);
      waitSbSize("stall_tag", 0, 500);
      base = pulse_count;
      repeat (50) @(negedge clk);
      checkOutput("stall_no_pulse", 32'(pulse_count - base), 32'h0);
      checkOutput("stall_out_enable", 32'(out_enable), 32'h1);
      checkOutput("stall_grant", 32'(grant), 32'h4);
      pushExpected(4'b0100, 8'h5A, 4'b0100, 1'b0);
      setStall(4'b0000);
      drainPackets("stall");

      // Reset while channel 1's packet is pacing after its tag.
      $display("[TB] reset mid-packet");
      setGate(1'b0);
      loadByte(1, 8'h71);
      loadByte(1, 8'h72);
      pushExpected(4'b0010, 8'hA1, 4'b0000, 1'b0);
      setGate(1'b1);
      waitSbSize("midrst_tag", 0, 500);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkResetState("midrst");
      @(posedge clk); #2;
      cmd_clear = 1'b1; gate = 1'b0;
      @(posedge clk); #2;
      cmd_clear = 1'b0; reset = 1'b0;
      loadByte(0, 8'h81);
      loadByte(1, 8'h82);
      pushExpected(4'b0001, 8'hA0, 4'b0000, 1'b0);
      pushExpected(4'b0001, 8'h81, 4'b0001, 1'b0);
      pushExpected(4'b0010, 8'hA1, 4'b0000, 1'b0);
      pushExpected(4'b0010, 8'h82, 4'b0010, 1'b0);
      setGate(1'b1);
      drainPackets("post_reset");

      checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/maple_fifo_arbiter.md
Name: maple_fifo_arbiter

Overview:
- Shares the single FX2 slave-FIFO stream writer (EP6 IN) between N_CH Maple bus channel requesters.
- Grants one requester per packet in round-robin order and prefixes each packet with a channel tag byte.
- Paces bytes to the writer's fixed per-byte cycle budget and enforces an inter-packet gap so the writer can reach PKTEND/IDLE.
- Sits between the per-port Maple receivers and the stream writer, driving its menable/mready/mdata inputs.

Parameters:
- N_CH, 4, number of requesters (2..8); CW = clog2(N_CH).
- START_CYCLES, 3, cycles out_enable is high before the first out_ready pulse (writer IDLE->SELECT_FIFO->IS_FULL->HAS_DATA).
- BYTE_CYCLES, 3, minimum cycles between consecutive out_ready pulses (writer HAS_DATA->SETUP_DATA->WRITE->HAS_DATA).
- GAP_CYCLES, 3, cycles out_enable is held low after a packet.
- MAX_BYTES, 255, payload byte limit per grant, excluding the tag; 8-bit counter.
- TAG_BASE, 8'hA0, tag byte = TAG_BASE | granted index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_enable  in  N_CH  per-requester packet-active level
- req_ready  in  N_CH  per-requester byte-valid level
- req_data  in  8*N_CH  byte of requester i on bits [8i+7:8i]
- req_ack  out  N_CH  one-cycle pulse: byte of requester i consumed
- grant  out  N_CH  one-hot current owner; all zero when none
- out_enable  out  1  to writer menable
- out_ready  out  1  to writer mready, single-cycle pulses only
- out_data  out  8  to writer mdata, stable from the pulse cycle until the next pulse
- truncated  out  1  one-cycle pulse when a grant is ended by MAX_BYTES

Behaviour:
- All outputs are registered.
- Reset values: grant=0, req_ack=0, out_enable=0, out_ready=0, out_data=0, truncated=0, last-owner pointer = N_CH-1, state IDLE.
- Reset has priority over everything, including mid-packet. Bench must allow the writer to be reset alongside.
- IDLE: when any req_enable is set, go to ARB next cycle.
- ARB: pick the first requester with req_enable set, searching from (last+1) mod N_CH upward with wrap. Set its grant bit, update last, clear byte counter, assert out_enable, go to START.
  - If no requester remains asserted at this point, return to IDLE with no grant.
- START: hold for START_CYCLES counting the ARB cycle as cycle 1. Then pulse out_ready with out_data = TAG_BASE | index, and go to PACE.
- PACE: hold for BYTE_CYCLES-1 cycles with out_ready low, then go to XFER.
- XFER, owner enable high and ready high: latch the byte to out_data, pulse out_ready and the owner's req_ack in the same cycle, increment the counter, then go to PACE.
  - If the counter reaches MAX_BYTES, go to GAP instead and pulse truncated.
- XFER, owner enable high and ready low: wait indefinitely.
- XFER, owner enable low: end the packet and go to GAP. A ready seen with enable low is not consumed and gets no ack.
- Requester contract: after req_ack, the requester must present a new byte or drop req_ready on the next cycle. The arbiter samples only in XFER, so a held ready is never double-counted.
- GAP: out_enable=0, grant=0, out_ready=0 for GAP_CYCLES, then IDLE.
- A truncated requester still holding enable competes again in round-robin order. It is not re-granted immediately if others are waiting.
- Owner enable dropping in START or PACE is registered and honoured at the next XFER entry. The tag is always sent.
- Non-owner enable changes during a grant have no effect.
- The writer's full/DROP path is invisible to this block. Pacing continues unchanged and the bytes are discarded downstream.

Test Plan:
- Single requester: reset; req_enable[1]=1; send 2 bytes 0x11, 0x22, then drop enable -> grant=4'b0010.
  - First out_ready 3 cycles after ARB with out_data=0xA1.
  - Then pulses carrying 0x11 and 0x22, each ≥3 cycles apart; two req_ack[1] pulses.
  - out_enable low 3 cycles, then IDLE.
- Round-robin: channels 0, 2, 3 all hold enable with 1 byte each -> grant order 0, 2, 3, 0; tags 0xA0, 0xA2, 0xA3; gap of 3 low out_enable cycles between packets.
- Wrap: last=3, requesters 0 and 3 active -> 0 is granted first.
- Truncation: MAX_BYTES=4 and requester 0 streams continuously -> exactly 4 acks and a truncated pulse; with requester 1 pending, the next grant goes to 1, not 0.
- Stall: granted channel holds enable with ready low for 50 cycles -> no out_ready and no ack, out_enable stays high. Ready then rises with 0x5A -> out_data=0x5A and ack on the same cycle.
- Reset mid-packet: assert reset during PACE -> next cycle all outputs are at reset values and grant=0. After release, channel 0 is granted first.
